cordic_vector_ip: RTL and testbench

CORDIC_VECTOR_IP -- requirements
Module: cordic_vector_ip

---
 rtl/cordic_vector_ip.sv | 263 ++++++++++++++++++++++++++
 tb/tb_cordic_vector_ip.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vector_ip.sv
// ---------------------------------------------------------------------------
// cordic_vector_ip
//
// Purpose
//   Iterative CORDIC in vectoring mode. It takes a Cartesian vector (x_in, y_in)
//   and returns its polar angle atan2(y_in, x_in) and its magnitude. The block
//   runs one micro-rotation per clock and processes one vector at a time.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   x_in/y_in valid (taken only while in_ready is high)
//   in_ready   out  1   block is idle and can accept a vector
//   x_in       in   24  signed Q1.22
//   y_in       in   24  signed Q1.22
//   out_valid  out  1   angle/mag valid, held until out_ready
//   out_ready  in   1   consumer accepts the result
//   angle      out  24  signed Q2.21 radians, range (-pi, pi]
//   mag        out  24  magnitude, Q1.22, saturated to 0x7FFFFF
//
// Parameter
//   CORDIC_STAGES  number of vectoring iterations, 1..22 (default 16)
//
// Configuration macro
//   CORDIC_VEC_GAIN_COMP_EN
//     defined   : an extra GAIN state scales the final x by 1/K (0x26DD3B,
//                 Q1.22), so mag is the true magnitude; adds one cycle.
//     undefined : mag is the raw final x, including the CORDIC gain (~1.64676).
// ---------------------------------------------------------------------------
module cordic_vector_ip #(
  parameter int CORDIC_STAGES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] x_in,
  input  logic [23:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] angle,
  output logic [23:0] mag
);

`ifdef CORDIC_VEC_GAIN_COMP_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    GAIN = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  // Angles in Q2.21 radians.
  localparam logic [23:0] HALF_PI     = 24'h3243F6;
  localparam logic [23:0] NEG_HALF_PI = 24'hCDBC0A;

  // The counter reaching this value marks the finalisation cycle that
  // follows the last micro-rotation.
  localparam logic [4:0] LAST_CNT = 5'(CORDIC_STAGES);

`ifdef CORDIC_VEC_GAIN_COMP_EN
  // 1/K in Q1.22, K being the accumulated CORDIC gain.
  localparam logic [23:0] GAIN_K = 24'h26DD3B;
`endif

  state_t             state_q, state_d;
  logic signed [25:0] x_q, x_d;
  logic signed [25:0] y_q, y_d;
  logic        [23:0] z_q, z_d;
  logic        [4:0]  cnt_q, cnt_d;
  logic               zero_q, zero_d;
  logic        [23:0] angle_q, angle_d;
  logic        [23:0] mag_q, mag_d;

  logic signed [25:0] xExt, yExt;
  logic signed [25:0] xShift, yShift;
  logic        [23:0] atanVal;
  logic        [23:0] magRaw;

  // Elementary angles round(atan(2^-i) * 2^21). From i = 8 onward the value
  // rounds to an exact power of two.
  function automatic logic [23:0] atanLut(input logic [4:0] idx);
    logic [23:0] val;
    case (idx)
      5'd0:    val = 24'h1921FB;
      5'd1:    val = 24'h0ED634;
      5'd2:    val = 24'h07D6DD;
      5'd3:    val = 24'h03FAB7;
      5'd4:    val = 24'h01FF56;
      5'd5:    val = 24'h00FFEB;
      5'd6:    val = 24'h007FFD;
      5'd7:    val = 24'h004000;
      5'd8:    val = 24'h002000;
      5'd9:    val = 24'h001000;
      5'd10:   val = 24'h000800;
      5'd11:   val = 24'h000400;
      5'd12:   val = 24'h000200;
      5'd13:   val = 24'h000100;
      5'd14:   val = 24'h000080;
      5'd15:   val = 24'h000040;
      5'd16:   val = 24'h000020;
      5'd17:   val = 24'h000010;
      5'd18:   val = 24'h000008;
      5'd19:   val = 24'h000004;
      5'd20:   val = 24'h000002;
      5'd21:   val = 24'h000001;
      default: val = 24'h000000;
    endcase
    return val;
  endfunction

  // Clamp a wide signed magnitude into the 24-bit output. After vectoring
  // the value is never negative, but clamping to zero keeps it well defined.
  function automatic logic [23:0] satMag(input logic signed [49:0] v);
    logic [23:0] r;
    if (v[49]) begin
      r = 24'h000000;
    end else if (v > 50'sd8388607) begin
      r = 24'h7FFFFF;
    end else begin
      r = v[23:0];
    end
    return r;
  endfunction

  // Sign-extend the inputs into the datapath. The two guard bits absorb the
  // CORDIC gain growth.
  assign xExt = {{2{x_in[23]}}, x_in};
  assign yExt = {{2{y_in[23]}}, y_in};

  // Both shifts use the pre-update x/y of the current iteration.
  assign xShift  = x_q >>> cnt_q;
  assign yShift  = y_q >>> cnt_q;
  assign atanVal = atanLut(cnt_q);

`ifdef CORDIC_VEC_GAIN_COMP_EN
  logic signed [49:0] gainProd;
  logic signed [49:0] gainScaled;

  // Q3.22 * Q1.22 gives Q.44. Shifting right by 22 returns to Q1.22 and
  // truncates the fraction.
  assign gainProd   = $signed({{24{x_q[25]}}, x_q} * {26'd0, GAIN_K});
  assign gainScaled = gainProd >>> 22;
  assign magRaw     = satMag(gainScaled);
`else
  assign magRaw     = satMag({{24{x_q[25]}}, x_q});
`endif

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

  // Next-state and datapath logic.
  // The pre-rotation folds the left half-plane into the right half-plane so
  // that the +/-1.74 rad CORDIC convergence range covers the whole circle.
  // A zero vector is flagged at capture because the iterations alone would
  // still accumulate angle on it.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d   = '0;
          zero_d  = (x_in == 24'd0) && (y_in == 24'd0);
          state_d = ITER;
          if (!x_in[23]) begin
            x_d = xExt;
            y_d = yExt;
            z_d = 24'h000000;
          end else if (!y_in[23]) begin
            x_d = yExt;
            y_d = -xExt;
            z_d = HALF_PI;
          end else begin
            x_d = -yExt;
            y_d = xExt;
            z_d = NEG_HALF_PI;
          end
        end
      end

      ITER: begin
        if (cnt_q == LAST_CNT) begin
          angle_d = zero_q ? 24'h000000 : z_q;
`ifdef CORDIC_VEC_GAIN_COMP_EN
          state_d = GAIN;
`else
          mag_d   = magRaw;
          state_d = DONE;
`endif
        end else begin
          if (!y_q[25]) begin
            x_d = x_q + yShift;
            y_d = y_q - xShift;
            z_d = z_q + atanVal;
          end else begin
            x_d = x_q - yShift;
            y_d = y_q + xShift;
            z_d = z_q - atanVal;
          end
          cnt_d = cnt_q + 5'd1;
        end
      end

`ifdef CORDIC_VEC_GAIN_COMP_EN
      GAIN: begin
        mag_d   = magRaw;
        state_d = DONE;
      end
`endif

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign angle     = angle_q;
  assign mag       = mag_q;

endmodule

// File: tb/tb_cordic_vector_ip.sv
// ---------------------------------------------------------------------------
// tb_cordic_vector_ip
//
// Directed bench for cordic_vector_ip. Expected angles and magnitudes are
// worked out by hand from atan2 and |v|. The raw CORDIC gain
// (~1.64676 for 16 stages) is applied when CORDIC_VEC_GAIN_COMP_EN is not
// defined. Angle tolerance covers the residual of the last micro-rotation
// (~atan(2^-15) = 64 LSB) plus truncation. Magnitude tolerance covers the
// accumulated shift truncation.
// ---------------------------------------------------------------------------
module tb_cordic_vector_ip;

  localparam int S = 16;
`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam int G = 1;
  localparam logic [23:0] MAG_HALF = 24'h200000;
  localparam logic [23:0] MAG_DIAG = 24'h2D413C;
  localparam logic [23:0] MAG_BIG  = 24'h5A827A;
  localparam int          TOL_BIG  = 48;
`else
  localparam int G = 0;
  localparam logic [23:0] MAG_HALF = 24'h34B246;
  localparam logic [23:0] MAG_DIAG = 24'h4A861B;
  localparam logic [23:0] MAG_BIG  = 24'h7FFFFF;
  localparam int          TOL_BIG  = 0;
`endif
  localparam int TOL_ANG = 96;
  localparam int TOL_MAG = 48;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] x_in;
  logic [23:0] y_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] angle;
  logic [23:0] mag;

  int checks;
  int errors;
  int lat;
  int hits;
  int t0, t1, t2;

  cordic_vector_ip #(.CORDIC_STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .angle     (angle),
    .mag       (mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact comparison.
  task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Comparison within +/- tol LSB, with 24-bit wrap so angles near +/-pi work.
  task automatic checkNear(input string tag, input logic [23:0] obs, input logic [23:0] exp,
                           input int tol);
    logic signed [23:0] d;
    logic ok;
    d  = obs - exp;
    ok = (d >= -tol) && (d <= tol);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h tol=%0d", tag, obs, exp, tol);
    end
  endtask

  // Present one vector; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [23:0] xv, input logic [23:0] yv);
    x_in     = xv;
    y_in     = yv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid; 0 means it never came.
  task automatic waitResult(output int latency);
    latency = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        latency = k;
        break;
      end
    end
  endtask

  task automatic runVector(input string tag, input logic [23:0] xv, input logic [23:0] yv,
                           input logic [23:0] expAng, input logic [23:0] expMag,
                           input int angTol, input int magTol);
    int l;
    applyStimulus(xv, yv);
    waitResult(l);
    checkOutput({tag, "_latency"}, 24'(l), 24'(S + 1 + G));
    checkNear({tag, "_angle"}, angle, expAng, angTol);
    checkNear({tag, "_mag"}, mag, expMag, magTol);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_idle_ready"}, {23'd0, in_ready}, 24'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;
    t0 = 0; t1 = 0; t2 = 0;

    #12;
    checkOutput("rst_in_ready", {23'd0, in_ready}, 24'd1);
    checkOutput("rst_out_valid", {23'd0, out_valid}, 24'd0);
    checkOutput("rst_angle", angle, 24'd0);
    checkOutput("rst_mag", mag, 24'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    runVector("v_pos_x",   24'h200000, 24'h000000, 24'h000000, MAG_HALF, TOL_ANG, TOL_MAG);
    runVector("v_diag",    24'h200000, 24'h200000, 24'h1921FB, MAG_DIAG, TOL_ANG, TOL_MAG);
    runVector("v_neg_x",   24'hE00000, 24'h000000, 24'h6487ED, MAG_HALF, TOL_ANG, TOL_MAG);
    runVector("v_neg_y",   24'h000000, 24'hE00000, 24'hCDBC0A, MAG_HALF, TOL_ANG, TOL_MAG);
    runVector("v_zero",    24'h000000, 24'h000000, 24'h000000, 24'h000000, 0, 0);
    runVector("v_q3",      24'hE00000, 24'hE00000, 24'hB49A0E, MAG_DIAG, TOL_ANG, TOL_MAG);
    runVector("v_q4",      24'h200000, 24'hE00000, 24'hE6DE05, MAG_DIAG, TOL_ANG, TOL_MAG);
    runVector("v_sat",     24'h400000, 24'h400000, 24'h1921FB, MAG_BIG, TOL_ANG, TOL_BIG);

    $display("[TB] output stall with competing input");
    applyStimulus(24'h200000, 24'h200000);
    waitResult(lat);
    checkOutput("stall_latency", 24'(lat), 24'(S + 1 + G));
    x_in     = 24'h100000;
    y_in     = 24'h000000;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_out_valid", {23'd0, out_valid}, 24'd1);
      checkOutput("stall_in_ready", {23'd0, in_ready}, 24'd0);
      checkNear("stall_angle", angle, 24'h1921FB, TOL_ANG);
      checkNear("stall_mag", mag, MAG_DIAG, TOL_MAG);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("release_in_ready", {23'd0, in_ready}, 24'd1);
    checkOutput("release_out_valid", {23'd0, out_valid}, 24'd0);
    @(posedge clk);
    #1;
    checkOutput("no_ghost_start", {23'd0, in_ready}, 24'd1);

    $display("[TB] reset during iterations");
    applyStimulus(24'h200000, 24'h200000);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_in_ready", {23'd0, in_ready}, 24'd1);
    checkOutput("abort_out_valid", {23'd0, out_valid}, 24'd0);
    checkOutput("abort_angle", angle, 24'd0);
    checkOutput("abort_mag", mag, 24'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    runVector("v_after_rst", 24'hE00000, 24'h000000, 24'h6487ED, MAG_HALF, TOL_ANG, TOL_MAG);

    $display("[TB] back-to-back throughput");
    x_in      = 24'h200000;
    y_in      = 24'h000000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    hits      = 0;
    for (int k = 1; k <= 600 && hits < 3; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (hits == 0) begin
          t0 = k;
          checkNear("b2b_angle", angle, 24'h000000, TOL_ANG);
        end else if (hits == 1) begin
          t1 = k;
        end else begin
          t2 = k;
        end
        hits++;
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("b2b_count", 24'(hits), 24'd3);
    checkOutput("b2b_first_latency", 24'(t0), 24'(S + 2 + G));
    checkOutput("b2b_period_1", 24'(t1 - t0), 24'(S + 3 + G));
    checkOutput("b2b_period_2", 24'(t2 - t1), 24'(S + 3 + G));
    checkOutput("b2b_end_idle", {23'd0, in_ready}, 24'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
